// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI target endpoint: FSM state codes,
// status bit positions, the default underrun fill byte and a saturating
// byte counter helper.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_UNDERRUN = 1;
  localparam int STAT_OVERRUN  = 2;
  localparam int STAT_ABORT    = 3;

  localparam logic [7:0]  FILL_BYTE_DEFAULT = 8'hFF;
  localparam logic [19:0] BYTE_CNT_MAX      = 20'hFFFFF;

  // Byte counter increment that sticks at the top value instead of wrapping.
  function automatic logic [19:0] sat_inc(input logic [19:0] value);
    return (value == BYTE_CNT_MAX) ? value : value + 20'd1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous serial-bus line, followed by
// a one-flop history register so rising and falling transitions of the
// synchronised level can be flagged for one clk.
module spi_sync_edge
  import spi_slave_pkg::*;
#(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STG-1:0] chain;
  logic                prev;

  // Shift the raw input through the synchroniser and remember the last synced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STG-2:0], din};
      prev  <= chain[SYNC_STG-1];
    end
  end

  assign dout = chain[SYNC_STG-1];
  assign rise = dout & ~prev;
  assign fall = ~dout & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI target endpoint. Oversamples ncs/sck/mosi in the clk domain,
// deserialises MSB-first bytes from mosi, serialises bytes onto miso and
// exchanges data with the local side through byte-wide req/vld handshakes.
// All four cpol/cpha modes are supported; frames are delimited by ncs.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int         SYNC_STG  = 2,
  parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_en,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        ncs,
  input  logic        sck,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic        tx_buf_vld,
  input  logic [7:0]  tx_buf_byte,
  output logic        tx_buf_req,
  input  logic        rx_buf_vld,
  output logic [7:0]  rx_buf_byte,
  output logic        rx_buf_req,
  output logic [19:0] byte_cnt,
  output logic [7:0]  spi_status
);

  logic ncs_s, ncs_rise, ncs_fall;
  logic sck_s, sck_rise, sck_fall;
  logic mosi_s;
  logic [SYNC_STG-1:0] mosi_chain;

  state_t state, next_state;
  logic   do_load, in_shift, abort_now;
  logic   lead_edge, trail_edge, sample_edge, shift_edge;
  logic   do_sample, do_shift, byte_end, reload;

  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] rx_word;
  logic [7:0] tx_shift;
  logic [7:0] tx_hold;
  logic [7:0] tx_next_byte;
  logic       tx_full, tx_full_next;
  logic       tx_capture, rx_accept, rx_drop;
  logic       stat_underrun, stat_overrun, stat_abort;

  spi_sync_edge #(.SYNC_STG(SYNC_STG)) u_ncs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ncs),
    .dout (ncs_s),
    .rise (ncs_rise),
    .fall (ncs_fall)
  );

  spi_sync_edge #(.SYNC_STG(SYNC_STG)) u_sck_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sck),
    .dout (sck_s),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  // mosi needs the same synchroniser depth as sck so the sampled data bit lines up with the detected edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_chain <= '0;
    end else begin
      mosi_chain <= {mosi_chain[SYNC_STG-2:0], mosi};
    end
  end

  assign mosi_s = mosi_chain[SYNC_STG-1];

  // Leading edge leaves the idle level, trailing edge returns to it; cpha picks which one samples.
  assign lead_edge   = cpol ? sck_fall : sck_rise;
  assign trail_edge  = cpol ? sck_rise : sck_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state plus the per-clk strobes that drive the datapath.
  always_comb begin
    next_state = state;
    do_load    = 1'b0;
    in_shift   = 1'b0;
    abort_now  = 1'b0;
    if (!spi_en) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ncs_fall) begin
            next_state = ST_LOAD;
          end
        end
        ST_LOAD: begin
          do_load    = 1'b1;
          next_state = ncs_s ? ST_IDLE : ST_SHIFT;
        end
        ST_SHIFT: begin
          if (ncs_rise) begin
            next_state = ST_IDLE;
            abort_now  = (bit_cnt != 3'd0);
          end else begin
            in_shift = 1'b1;
          end
        end
        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  assign do_sample    = in_shift & sample_edge;
  assign do_shift     = in_shift & shift_edge;
  assign byte_end     = do_sample & (bit_cnt == 3'd7);
  assign reload       = do_load | byte_end;
  assign tx_next_byte = tx_full ? tx_hold : FILL_BYTE;
  assign rx_word      = {rx_shift, mosi_s};
  assign tx_capture   = tx_buf_vld & tx_buf_req;
  assign rx_accept    = rx_buf_vld & rx_buf_req;
  assign rx_drop      = byte_end & rx_buf_req & ~rx_accept;

  // Holding register occupancy: a load empties it, a handshake fills it (never both in one clk).
  always_comb begin
    tx_full_next = tx_full;
    if (reload && tx_full) begin
      tx_full_next = 1'b0;
    end else if (tx_capture) begin
      tx_full_next = 1'b1;
    end
  end

  // Bit position within the byte and the incoming data shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
    end else if (do_load) begin
      bit_cnt <= 3'd0;
    end else if (do_sample) begin
      bit_cnt  <= bit_cnt + 3'd1;
      rx_shift <= rx_word[6:0];
    end
  end

  // Tx holding register and its request, which mirrors emptiness while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_full    <= 1'b0;
      tx_hold    <= 8'd0;
      tx_buf_req <= 1'b0;
    end else begin
      tx_full    <= tx_full_next;
      tx_buf_req <= spi_en & ~tx_full_next;
      if (tx_capture) begin
        tx_hold <= tx_buf_byte;
      end
    end
  end

  // Outgoing shifter and miso: bit7 is ready at each load, later bits follow on shift edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= 8'd0;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
    end else begin
      miso_oe <= (next_state == ST_SHIFT);
      if (reload) begin
        tx_shift <= tx_next_byte;
        if (do_load || !cpha) begin
          miso <= tx_next_byte[7];
        end
      end else if (do_shift) begin
        if (bit_cnt == 3'd0) begin
          if (cpha) begin
            miso <= tx_shift[7];
          end
        end else begin
          miso     <= tx_shift[6];
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end else if (next_state == ST_IDLE) begin
        miso <= 1'b0;
      end
    end
  end

  // Rx buffer handshake; an accept in the same clk as a byte end frees room for the new byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_buf_byte <= 8'd0;
      rx_buf_req  <= 1'b0;
      byte_cnt    <= 20'd0;
    end else begin
      if (!spi_en) begin
        rx_buf_req <= 1'b0;
      end else if (byte_end) begin
        if (!rx_buf_req || rx_accept) begin
          rx_buf_byte <= rx_word;
          rx_buf_req  <= 1'b1;
        end
      end else if (rx_accept) begin
        rx_buf_req <= 1'b0;
      end
      if (do_load) begin
        byte_cnt <= 20'd0;
      end else if (byte_end) begin
        byte_cnt <= sat_inc(byte_cnt);
      end
    end
  end

  // Sticky error flags, cleared when a new frame loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_underrun <= 1'b0;
      stat_overrun  <= 1'b0;
      stat_abort    <= 1'b0;
    end else if (do_load) begin
      stat_underrun <= ~tx_full;
      stat_overrun  <= 1'b0;
      stat_abort    <= 1'b0;
    end else begin
      if (byte_end && !tx_full) begin
        stat_underrun <= 1'b1;
      end
      if (rx_drop) begin
        stat_overrun <= 1'b1;
      end
      if (abort_now) begin
        stat_abort <= 1'b1;
      end
    end
  end

  // Assemble the status byte from the busy level and the sticky flags.
  always_comb begin
    spi_status                = 8'd0;
    spi_status[STAT_BUSY]     = (state != ST_IDLE);
    spi_status[STAT_UNDERRUN] = stat_underrun;
    spi_status[STAT_OVERRUN]  = stat_overrun;
    spi_status[STAT_ABORT]    = stat_abort;
  end

endmodule
